// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register countdown scoreboard driving stall/bubble/flush and perf counters.
// Optional forwarding threshold selected by HAZARD_FWD_EN.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_LAT  = 7,
    parameter int PERF_W   = 32,
    parameter int CNT_W    = $clog2(MAX_LAT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [ADDR_W-1:0]   id_rs1,
    input  logic                id_rs1_used,
    input  logic [ADDR_W-1:0]   id_rs2,
    input  logic                id_rs2_used,
    input  logic [ADDR_W-1:0]   id_rd,
    input  logic                id_rd_we,
    input  logic [CNT_W-1:0]    id_lat,
    input  logic                take_branch,
    output logic                stall,
    output logic                bubble,
    output logic                flush_if_id,
    output logic                flush_id_ex,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [PERF_W-1:0]   stall_cnt,
    output logic [PERF_W-1:0]   flush_cnt
);

    localparam logic [CNT_W-1:0] MAX_LAT_C = CNT_W'(MAX_LAT);
`ifdef HAZARD_FWD_EN
    localparam logic [CNT_W-1:0] THR = CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] THR = '0;
`endif

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_REGS-1:0]            busy_mask_q, busy_mask_d;
    logic [PERF_W-1:0]              stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0]              flush_cnt_q, flush_cnt_d;

    logic [NUM_REGS-1:0] haz_vec;
    logic [CNT_W-1:0]    lat_eff;
    logic                issue;

    always_comb begin
        haz_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            haz_vec[r] = cnt_q[r] > THR;
        end
        stall = id_valid && !take_branch &&
                ((id_rs1_used && haz_vec[id_rs1]) || (id_rs2_used && haz_vec[id_rs2]));
        bubble      = stall || take_branch;
        flush_if_id = take_branch;
        flush_id_ex = take_branch;
        issue       = id_valid && !stall && !take_branch;
        lat_eff     = (id_lat > MAX_LAT_C) ? MAX_LAT_C : id_lat;
    end

    // Issue overwrites the counter (also covers WAW); everything else counts down.
    always_comb begin
        cnt_d       = '0;
        busy_mask_d = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (issue && id_rd_we && (id_rd == ADDR_W'(r)) && (lat_eff != '0)) begin
                cnt_d[r] = lat_eff;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end else begin
                cnt_d[r] = cnt_q[r];
            end
            busy_mask_d[r] = cnt_d[r] != '0;
        end
        stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + PERF_W'(1) : stall_cnt_q;
        flush_cnt_d = (take_branch && (flush_cnt_q != '1)) ? flush_cnt_q + PERF_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            busy_mask_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            busy_mask_q <= busy_mask_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign busy_mask = busy_mask_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
